sdes_round_sequencer: RTL and testbench

- Multi-cycle controller that shares one external SDES round-function unit (fk) between an encrypt requester and a decrypt requester.
- Arbitrates round-robin between the two requesters and latches the block and key.
- Generates K1/K2 in registers and sequences IP -> fk -> SW -> fk -> IP^-1, then returns the 8-bit result with a one-cycle ack.
- Sits between the 1 Hz plaintext counter / key switches and the BCD display path.

---
 rtl/sdes_round_sequencer_if.sv | 28 ++
 rtl/sdes_round_sequencer.sv | 141 ++++++++++++++
 tb/tb_sdes_round_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdes_round_sequencer_if.sv
// Bundle between the SDES round sequencer, its two requesters and the
// shared external fk round-function unit.
interface sdes_round_sequencer_if;
    logic [9:0] key;
    logic       enc_req;
    logic [7:0] enc_data;
    logic       enc_ack;
    logic       dec_req;
    logic [7:0] dec_data;
    logic       dec_ack;
    logic [7:0] result;
    logic       busy;
    logic [7:0] fk_in;
    logic [7:0] fk_key;
    logic [7:0] fk_out;

    // Requester/fk side: drives requests, key, data and the fk result.
    modport master (
        output key, enc_req, enc_data, dec_req, dec_data, fk_out,
        input  enc_ack, dec_ack, result, busy, fk_in, fk_key
    );

    // Sequencer side.
    modport slave (
        input  key, enc_req, enc_data, dec_req, dec_data, fk_out,
        output enc_ack, dec_ack, result, busy, fk_in, fk_key
    );
endinterface

// File: rtl/sdes_round_sequencer.sv
// SDES round sequencer: arbitrates encrypt/decrypt requests round-robin,
// derives K1/K2 and steps one external fk unit through IP -> fk -> SW -> fk
// -> IP^-1, returning the result with a one-cycle ack.
module sdes_round_sequencer (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    sdes_round_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_R1,
        S_R2,
        S_DONE
    } state_t;

    state_t     r_state;
    logic       r_last_dec;
    logic       r_mode;
    logic [7:0] r_data;
    logic [9:0] r_key;
    logic [7:0] r_k1;
    logic [7:0] r_k2;
    logic [7:0] r_fk_in;
    logic [7:0] r_fk_key;
    logic [7:0] r_result;
    logic       r_enc_ack;
    logic       r_dec_ack;
    logic       r_busy;

    logic       w_any_req;
    logic       w_grant_dec;
    logic [7:0] w_k1;
    logic [7:0] w_k2;

    // Permutations; standard bit n of a W-bit vector is index W-n.
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] x);
        return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
    endfunction

    function automatic logic [9:0] ls1(input logic [9:0] x);
        return {x[8:5], x[9], x[3:0], x[4]};
    endfunction

    function automatic logic [9:0] ls2(input logic [9:0] x);
        return {x[7:5], x[9:8], x[2:0], x[4:3]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] d);
        return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] d);
        return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
    endfunction

    // Grant decision and subkey derivation from the latched key.
    always_comb begin
        w_any_req   = bus.enc_req | bus.dec_req;
        w_grant_dec = bus.dec_req & (~bus.enc_req | ~r_last_dec);
        w_k1        = p8(ls1(p10(r_key)));
        w_k2        = p8(ls2(ls1(p10(r_key))));
    end

    // Sequencer FSM with all outputs registered.
    // fk_in/fk_key are loaded one state early (on the edge entering R1/R2)
    // so the external fk sees them for the whole round cycle.
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_last_dec <= 1'b1;
            r_mode     <= 1'b0;
            r_data     <= '0;
            r_key      <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_fk_in    <= '0;
            r_fk_key   <= '0;
            r_result   <= '0;
            r_enc_ack  <= 1'b0;
            r_dec_ack  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_KEY;
                        r_busy     <= 1'b1;
                        r_mode     <= w_grant_dec;
                        r_last_dec <= w_grant_dec;
                        r_data     <= w_grant_dec ? bus.dec_data : bus.enc_data;
                        r_key      <= bus.key;
                    end
                end
                S_KEY: begin
                    r_state  <= S_R1;
                    r_k1     <= w_k1;
                    r_k2     <= w_k2;
                    r_fk_in  <= ip(r_data);
                    r_fk_key <= r_mode ? w_k2 : w_k1;
                end
                S_R1: begin
                    r_state  <= S_R2;
                    r_fk_in  <= {bus.fk_out[3:0], bus.fk_out[7:4]};
                    r_fk_key <= r_mode ? r_k1 : r_k2;
                end
                S_R2: begin
                    r_state   <= S_DONE;
                    r_result  <= ip_inv(bus.fk_out);
                    r_enc_ack <= ~r_mode;
                    r_dec_ack <= r_mode;
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_enc_ack <= 1'b0;
                    r_dec_ack <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_enc_ack <= 1'b0;
                    r_dec_ack <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enc_ack = r_enc_ack;
    assign bus.dec_ack = r_dec_ack;
    assign bus.result  = r_result;
    assign bus.busy    = r_busy;
    assign bus.fk_in   = r_fk_in;
    assign bus.fk_key  = r_fk_key;

endmodule

// File: tb/tb_sdes_round_sequencer.sv
// Scoreboard bench for sdes_round_sequencer with a table-driven SDES model
// that also stands in for the external fk unit.
module tb_sdes_round_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    sdes_round_sequencer_if bus();

    sdes_round_sequencer dut (
        .CLOCK_50(clk),
        .rst     (rst_n),
        .bus     (bus)
    );

    int T_P10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int T_P8[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int T_IP[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int T_IPI[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int T_EP[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int T_P4[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int S0[16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    int S1[16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

    // Generic permutation: output position j takes standard input bit t[j].
    function automatic logic [9:0] perm(input logic [9:0] x, input int n_in,
                                        input int t[10], input int n_out);
        logic [9:0] r;
        r = '0;
        for (int j = 0; j < n_out; j++) r[n_out-1-j] = x[n_in - t[j]];
        return r;
    endfunction

    function automatic logic [9:0] rot_halves(input logic [9:0] x, input int s);
        int hi, lo;
        hi = int'(x[9:5]);
        lo = int'(x[4:0]);
        hi = ((hi << s) | (hi >> (5 - s))) & 31;
        lo = ((lo << s) | (lo >> (5 - s))) & 31;
        return 10'(hi * 32 + lo);
    endfunction

    function automatic logic [7:0] subkey(input logic [9:0] k, input int n);
        logic [9:0] t;
        t = perm(k, 10, T_P10, 10);
        t = rot_halves(t, 1);
        if (n == 2) t = rot_halves(t, 2);
        t = perm(t, 10, T_P8, 8);
        return t[7:0];
    endfunction

    function automatic logic [7:0] fk_model(input logic [7:0] blk, input logic [7:0] sk);
        logic [9:0] ep, p;
        logic [7:0] t;
        int s0, s1;
        ep = perm({6'b0, blk[3:0]}, 4, T_EP, 8);
        t  = ep[7:0] ^ sk;
        s0 = S0[(int'(t[7]) * 2 + int'(t[4])) * 4 + int'(t[6]) * 2 + int'(t[5])];
        s1 = S1[(int'(t[3]) * 2 + int'(t[0])) * 4 + int'(t[2]) * 2 + int'(t[1])];
        p  = perm(10'(s0 * 4 + s1), 4, T_P4, 4);
        return {blk[7:4] ^ p[3:0], blk[3:0]};
    endfunction

    function automatic logic [7:0] ip_model(input logic [7:0] d);
        logic [9:0] r;
        r = perm({2'b0, d}, 8, T_IP, 8);
        return r[7:0];
    endfunction

    function automatic logic [7:0] sdes_model(input logic [7:0] d, input logic [9:0] k,
                                              input logic dec);
        logic [7:0] ka, kb, a, b;
        logic [9:0] r;
        ka = subkey(k, dec ? 2 : 1);
        kb = subkey(k, dec ? 1 : 2);
        a  = fk_model(ip_model(d), ka);
        a  = {a[3:0], a[7:4]};
        b  = fk_model(a, kb);
        r  = perm({2'b0, b}, 8, T_IPI, 8);
        return r[7:0];
    endfunction

    assign bus.fk_out = fk_model(bus.fk_in, bus.fk_key);

    typedef struct {
        logic       dec;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops the scoreboard on every ack and checks side, value, latency.
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus.busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
            prev_busy = bus.busy;
            if (bus.enc_ack && bus.dec_ack) fail_now("both_acks_high");
            if (bus.enc_ack || bus.dec_ack) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_side", 32'(bus.dec_ack), 32'(e.dec));
                    chk("result", 32'(bus.result), 32'(e.val));
                    chk("ack_latency", busy_cnt, 4);
                end
            end
        end
    end

    task automatic issue(input logic dec, input logic [7:0] d, input logic [9:0] k,
                         input logic [7:0] expv);
        exp_t e;
        @(negedge clk);
        bus.key = k;
        if (dec) begin
            bus.dec_data = d;
            bus.dec_req  = 1'b1;
        end else begin
            bus.enc_data = d;
            bus.enc_req  = 1'b1;
        end
        e.dec = dec;
        e.val = expv;
        exp_q.push_back(e);
    endtask

    // Waits for this side's ack, dropping the request in the ack cycle.
    // With scramble set, key and data are randomised every cycle in flight.
    task automatic wait_ack(input logic dec, input bit scramble);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (dec ? bus.dec_ack : bus.enc_ack) got = 1'b1;
            else if (scramble) begin
                bus.key      = 10'($urandom);
                bus.enc_data = 8'($urandom);
                bus.dec_data = 8'($urandom);
            end
        end
        if (!got) fail_now("ack_timeout");
        if (dec) bus.dec_req = 1'b0;
        else     bus.enc_req = 1'b0;
    endtask

    task automatic do_op(input logic dec, input logic [7:0] d, input logic [9:0] k);
        issue(dec, d, k, sdes_model(d, k, dec));
        wait_ack(dec, 1'b0);
    endtask

    // Returns at the negedge of the R1 cycle (second busy cycle).
    task automatic wait_r1();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        if (!seen) fail_now("busy_timeout");
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [9:0] KAT_KEY = 10'b1010000010;

    initial begin
        logic [7:0] e0, e1, d0, d1, c;
        logic [9:0] k;
        int acks, enc_seen, dec_seen;
        exp_t e;

        bus.key = '0; bus.enc_req = 1'b0; bus.enc_data = '0;
        bus.dec_req = 1'b0; bus.dec_data = '0;

        #15;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_acks", 32'({bus.enc_ack, bus.dec_ack}), 0);
        chk("rst_fk_in", 32'(bus.fk_in), 0);
        chk("rst_fk_key", 32'(bus.fk_key), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer encrypt, with K1 checked on the fk bus during R1.
        issue(1'b0, 8'b10010111, KAT_KEY, 8'b00111000);
        wait_r1();
        chk("kat_enc_r1_key", 32'(bus.fk_key), 32'(8'b10100100));
        chk("kat_enc_r1_in", 32'(bus.fk_in), 32'(ip_model(8'b10010111)));
        wait_ack(1'b0, 1'b0);
        chk("kat_enc_result", 32'(bus.result), 32'(8'b00111000));

        // Known-answer decrypt: K2 must be on the fk bus during R1.
        issue(1'b1, 8'b00111000, KAT_KEY, 8'b10010111);
        wait_r1();
        chk("kat_dec_r1_key", 32'(bus.fk_key), 32'(8'b01000011));
        wait_ack(1'b1, 1'b0);
        chk("kat_dec_result", 32'(bus.result), 32'(8'b10010111));

        // Reset in mid-R1: abort, clear, and no ack afterwards.
        issue(1'b0, 8'h5A, 10'h2C3, 8'h00);
        wait_r1();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_result", 32'(bus.result), 0);
        chk("midrst_acks", 32'({bus.enc_ack, bus.dec_ack}), 0);
        exp_q.delete();
        bus.enc_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Both requests held: enc, dec, enc, dec from a fresh pointer.
        pulse_reset();
        k  = 10'($urandom);
        e0 = 8'($urandom); e1 = 8'($urandom);
        d0 = 8'($urandom); d1 = 8'($urandom);
        @(negedge clk);
        bus.key = k;
        bus.enc_data = e0; bus.dec_data = d0;
        bus.enc_req = 1'b1; bus.dec_req = 1'b1;
        e.dec = 1'b0; e.val = sdes_model(e0, k, 1'b0); exp_q.push_back(e);
        e.dec = 1'b1; e.val = sdes_model(d0, k, 1'b1); exp_q.push_back(e);
        e.dec = 1'b0; e.val = sdes_model(e1, k, 1'b0); exp_q.push_back(e);
        e.dec = 1'b1; e.val = sdes_model(d1, k, 1'b1); exp_q.push_back(e);
        acks = 0; enc_seen = 0; dec_seen = 0;
        for (int i = 0; i < 60 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.enc_ack) begin
                acks++; enc_seen++;
                if (enc_seen == 1) bus.enc_data = e1;
                else bus.enc_req = 1'b0;
            end
            if (bus.dec_ack) begin
                acks++; dec_seen++;
                if (dec_seen == 1) bus.dec_data = d1;
                else bus.dec_req = 1'b0;
            end
        end
        chk("simul_ack_count", acks, 4);
        bus.enc_req = 1'b0; bus.dec_req = 1'b0;

        // Key/data scrambled after grant must not disturb the operation.
        for (int i = 0; i < 4; i++) begin
            logic dd;
            dd = i[0];
            k  = 10'($urandom);
            c  = 8'($urandom);
            issue(dd, c, k, sdes_model(c, k, dd));
            wait_ack(dd, 1'b1);
        end

        // Random single operations.
        for (int i = 0; i < 30; i++) begin
            do_op(1'($urandom), 8'($urandom), 10'($urandom));
        end

        // Round-trip sweep with key 25.
        for (int v = 0; v <= 25; v++) begin
            c = sdes_model(8'(v), 10'd25, 1'b0);
            do_op(1'b0, 8'(v), 10'd25);
            issue(1'b1, c, 10'd25, 8'(v));
            wait_ack(1'b1, 1'b0);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
